pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the ID/EX pipeline register and its neighbours in the 5-stage MIPS pipeline.
- Detects load-use hazards between the instruction in IF/ID and a load in ID/EX.
- Reacts to taken branches resolved in MEM.
- Drives PC write-enable, IF/ID write-enable and flush, ID/EX bubble (zero all control fields on load) and EX/MEM control flush.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard and flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Inc,
  output logic [WIDTH-1:0] Count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (Inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall and taken-branch flush sequencing around the ID/EX register,
// with saturating stall/flush event counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [4:0]           IFID_RS,
  input  logic [4:0]           IFID_RT,
  input  logic                 IFID_UsesRS,
  input  logic                 IFID_UsesRT,
  input  logic                 IDEX_MemRead,
  input  logic [4:0]           IDEX_RT,
  input  logic                 BranchTaken,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic                 IFIDFlush,
  output logic                 IDEXBubble,
  output logic                 EXMEMFlush,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int unsigned MaxCycles = max_u(LOAD_STALL_CYCLES, FLUSH_CYCLES);
  // cnt only ever holds MaxCycles-1 down to 1.
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] StallReload = CntW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CntW-1:0] FlushReload = CntW'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hazard;
  logic            stall_inc, flush_inc;

  assign hazard = IDEX_MemRead && (IDEX_RT != REG_ZERO) &&
                  ((IFID_UsesRS && (IDEX_RT == IFID_RS)) ||
                   (IFID_UsesRT && (IDEX_RT == IFID_RT)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    EXMEMFlush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    // A taken branch wins in every state: it aborts a stall and restarts a flush.
    if (BranchTaken) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      EXMEMFlush = 1'b1;
      flush_inc  = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        cnt_d   = FlushReload;
      end else begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (hazard) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            stall_inc  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = StStall;
              cnt_d   = StallReload;
            end
          end
        end
        StStall: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
          stall_inc  = 1'b1;
          cnt_d      = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StRun;
          end
        end
        StFlush: begin
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b1;
          cnt_d      = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end

    // Held in reset the pipe is filled with NOPs regardless of state.
    if (!Rst) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      EXMEMFlush = 1'b1;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .Inc  (stall_inc),
    .Count(StallCount)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_flush_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .Inc  (flush_inc),
    .Count(FlushCount)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl across four parameterisations sharing one stimulus.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic       mem_read;
    logic [4:0] idex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       br;
  } stim_t;

  typedef struct {
    logic [4:0]  outs;   // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, EXMEMFlush}
    int unsigned stall;
    int unsigned flush;
  } exp_t;

  localparam logic [4:0] ORun   = 5'b11000;
  localparam logic [4:0] ORst   = 5'b00111;
  localparam logic [4:0] OStall = 5'b00010;
  localparam logic [4:0] OBr    = 5'b11111;
  localparam logic [4:0] OFl    = 5'b11110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic       uses_rs = 1'b0, uses_rt = 1'b0, mem_read = 1'b0, br = 1'b0;

  wire [4:0]  out_a, out_b, out_c, out_d;
  wire [15:0] stall_a, flush_a, stall_b, flush_b, stall_d, flush_d;
  wire [3:0]  stall_c, flush_c;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_a (
    .Clk(clk), .Rst(rst), .IFID_RS(ifid_rs), .IFID_RT(ifid_rt), .IFID_UsesRS(uses_rs),
    .IFID_UsesRT(uses_rt), .IDEX_MemRead(mem_read), .IDEX_RT(idex_rt), .BranchTaken(br),
    .PCWrite(out_a[4]), .IFIDWrite(out_a[3]), .IFIDFlush(out_a[2]), .IDEXBubble(out_a[1]),
    .EXMEMFlush(out_a[0]), .StallCount(stall_a), .FlushCount(flush_a)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) u_b (
    .Clk(clk), .Rst(rst), .IFID_RS(ifid_rs), .IFID_RT(ifid_rt), .IFID_UsesRS(uses_rs),
    .IFID_UsesRT(uses_rt), .IDEX_MemRead(mem_read), .IDEX_RT(idex_rt), .BranchTaken(br),
    .PCWrite(out_b[4]), .IFIDWrite(out_b[3]), .IFIDFlush(out_b[2]), .IDEXBubble(out_b[1]),
    .EXMEMFlush(out_b[0]), .StallCount(stall_b), .FlushCount(flush_b)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_WIDTH(4)) u_c (
    .Clk(clk), .Rst(rst), .IFID_RS(ifid_rs), .IFID_RT(ifid_rt), .IFID_UsesRS(uses_rs),
    .IFID_UsesRT(uses_rt), .IDEX_MemRead(mem_read), .IDEX_RT(idex_rt), .BranchTaken(br),
    .PCWrite(out_c[4]), .IFIDWrite(out_c[3]), .IFIDFlush(out_c[2]), .IDEXBubble(out_c[1]),
    .EXMEMFlush(out_c[0]), .StallCount(stall_c), .FlushCount(flush_c)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(4), .CNT_WIDTH(16)) u_d (
    .Clk(clk), .Rst(rst), .IFID_RS(ifid_rs), .IFID_RT(ifid_rt), .IFID_UsesRS(uses_rs),
    .IFID_UsesRT(uses_rt), .IDEX_MemRead(mem_read), .IDEX_RT(idex_rt), .BranchTaken(br),
    .PCWrite(out_d[4]), .IFIDWrite(out_d[3]), .IFIDFlush(out_d[2]), .IDEXBubble(out_d[1]),
    .EXMEMFlush(out_d[0]), .StallCount(stall_d), .FlushCount(flush_d)
  );

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.mem_read = 1'b0; s.idex_rt = '0; s.rs = '0; s.rt = '0;
    s.uses_rs = 1'b0; s.uses_rt = 1'b0; s.br = 1'b0;
    return s;
  endfunction

  function automatic stim_t haz_rs(input logic [4:0] r);
    stim_t s = idle();
    s.mem_read = 1'b1; s.idex_rt = r; s.rs = r; s.uses_rs = 1'b1;
    return s;
  endfunction

  function automatic exp_t ex(input logic [4:0] o, input int unsigned st, input int unsigned fl);
    exp_t e;
    e.outs = o; e.stall = st; e.flush = fl;
    return e;
  endfunction

  // Drive one cycle's inputs just after the edge, queue its expectation, land on the negedge.
  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst = s.rst; mem_read = s.mem_read; idex_rt = s.idex_rt; ifid_rs = s.rs; ifid_rt = s.rt;
    uses_rs = s.uses_rs; uses_rt = s.uses_rt; br = s.br;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; mem_read = 1'b0; br = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    stim_t sq[$];
    exp_t  eq[$];
    stim_t s;
    s = idle(); s.rst = 1'b0;
    sq.push_back(s);                eq.push_back(ex(ORst, 0, 0));
    s = haz_rs(5'd8); s.rst = 1'b0; s.br = 1'b1;
    sq.push_back(s);                eq.push_back(ex(ORst, 0, 0));
    s = idle(); s.rst = 1'b0;
    sq.push_back(s);                eq.push_back(ex(ORst, 0, 0));
    sq.push_back(idle());           eq.push_back(ex(ORun, 0, 0));
    for (int i = 0; i < sq.size(); i++) begin
      exp_t e;
      step(sq[i], eq[i]);
      e = sb_q.pop_front();
      checks += 3;
      if (out_a !== e.outs) begin
        errors++; $display("FAIL reset[%0d] outs got %b want %b", i, out_a, e.outs);
      end
      if (stall_a !== 16'(e.stall)) begin
        errors++; $display("FAIL reset[%0d] stall got %0d want %0d", i, stall_a, e.stall);
      end
      if (flush_a !== 16'(e.flush)) begin
        errors++; $display("FAIL reset[%0d] flush got %0d want %0d", i, flush_a, e.flush);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t sq[$];
    exp_t  eq[$];
    stim_t s;
    do_reset();
    sq.push_back(haz_rs(5'd8));     eq.push_back(ex(OStall, 0, 0));
    sq.push_back(idle());           eq.push_back(ex(ORun, 1, 0));
    sq.push_back(haz_rs(5'd0));     eq.push_back(ex(ORun, 1, 0));
    s = haz_rs(5'd8); s.uses_rs = 1'b0;
    sq.push_back(s);                eq.push_back(ex(ORun, 1, 0));
    s = idle(); s.mem_read = 1'b1; s.idex_rt = 5'd9; s.rt = 5'd9; s.uses_rt = 1'b1;
    sq.push_back(s);                eq.push_back(ex(OStall, 1, 0));
    sq.push_back(idle());           eq.push_back(ex(ORun, 2, 0));
    s = haz_rs(5'd8); s.mem_read = 1'b0;
    sq.push_back(s);                eq.push_back(ex(ORun, 2, 0));
    for (int i = 0; i < sq.size(); i++) begin
      exp_t e;
      step(sq[i], eq[i]);
      e = sb_q.pop_front();
      checks += 2;
      if (out_a !== e.outs) begin
        errors++; $display("FAIL load_use[%0d] outs got %b want %b", i, out_a, e.outs);
      end
      if (stall_a !== 16'(e.stall)) begin
        errors++; $display("FAIL load_use[%0d] stall got %0d want %0d", i, stall_a, e.stall);
      end
    end
  endtask

  task automatic test_multi_stall();
    stim_t sq[$];
    exp_t  eq[$];
    stim_t s;
    do_reset();
    s = idle(); s.mem_read = 1'b1; s.idex_rt = 5'd5; s.rt = 5'd5; s.uses_rt = 1'b1;
    sq.push_back(s);                eq.push_back(ex(OStall, 0, 0));
    sq.push_back(idle());           eq.push_back(ex(OStall, 1, 0));
    sq.push_back(idle());           eq.push_back(ex(OStall, 2, 0));
    sq.push_back(idle());           eq.push_back(ex(ORun, 3, 0));
    sq.push_back(idle());           eq.push_back(ex(ORun, 3, 0));
    for (int i = 0; i < sq.size(); i++) begin
      exp_t e;
      step(sq[i], eq[i]);
      e = sb_q.pop_front();
      checks += 2;
      if (out_b !== e.outs) begin
        errors++; $display("FAIL multi_stall[%0d] outs got %b want %b", i, out_b, e.outs);
      end
      if (stall_b !== 16'(e.stall)) begin
        errors++; $display("FAIL multi_stall[%0d] stall got %0d want %0d", i, stall_b, e.stall);
      end
    end
  endtask

  task automatic test_branch_vs_hazard();
    stim_t sq[$];
    exp_t  eq[$];
    stim_t s;
    do_reset();
    s = haz_rs(5'd8); s.br = 1'b1;
    sq.push_back(s);                eq.push_back(ex(OBr, 0, 0));
    sq.push_back(idle());           eq.push_back(ex(ORun, 0, 1));
    sq.push_back(haz_rs(5'd4));     eq.push_back(ex(OStall, 0, 1));
    sq.push_back(idle());           eq.push_back(ex(ORun, 1, 1));
    for (int i = 0; i < sq.size(); i++) begin
      exp_t e;
      step(sq[i], eq[i]);
      e = sb_q.pop_front();
      checks += 3;
      if (out_a !== e.outs) begin
        errors++; $display("FAIL br_haz[%0d] outs got %b want %b", i, out_a, e.outs);
      end
      if (stall_a !== 16'(e.stall)) begin
        errors++; $display("FAIL br_haz[%0d] stall got %0d want %0d", i, stall_a, e.stall);
      end
      if (flush_a !== 16'(e.flush)) begin
        errors++; $display("FAIL br_haz[%0d] flush got %0d want %0d", i, flush_a, e.flush);
      end
    end
    sq.delete();
    eq.delete();
    do_reset();
    sq.push_back(haz_rs(5'd8));     eq.push_back(ex(OStall, 0, 0));
    s = idle(); s.br = 1'b1;
    sq.push_back(s);                eq.push_back(ex(OBr, 1, 0));
    sq.push_back(haz_rs(5'd8));     eq.push_back(ex(OFl, 1, 1));
    sq.push_back(idle());           eq.push_back(ex(ORun, 1, 1));
    for (int i = 0; i < sq.size(); i++) begin
      exp_t e;
      step(sq[i], eq[i]);
      e = sb_q.pop_front();
      checks += 3;
      if (out_b !== e.outs) begin
        errors++; $display("FAIL stall_abort[%0d] outs got %b want %b", i, out_b, e.outs);
      end
      if (stall_b !== 16'(e.stall)) begin
        errors++; $display("FAIL stall_abort[%0d] stall got %0d want %0d", i, stall_b, e.stall);
      end
      if (flush_b !== 16'(e.flush)) begin
        errors++; $display("FAIL stall_abort[%0d] flush got %0d want %0d", i, flush_b, e.flush);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t sq[$];
    exp_t  eq[$];
    stim_t s;
    do_reset();
    s = idle(); s.br = 1'b1;
    sq.push_back(s);                eq.push_back(ex(OBr, 0, 0));
    sq.push_back(s);                eq.push_back(ex(OBr, 0, 1));
    sq.push_back(idle());           eq.push_back(ex(OFl, 0, 2));
    sq.push_back(idle());           eq.push_back(ex(ORun, 0, 2));
    for (int i = 0; i < sq.size(); i++) begin
      exp_t e;
      step(sq[i], eq[i]);
      e = sb_q.pop_front();
      checks += 2;
      if (out_b !== e.outs) begin
        errors++; $display("FAIL back_to_back[%0d] outs got %b want %b", i, out_b, e.outs);
      end
      if (flush_b !== 16'(e.flush)) begin
        errors++; $display("FAIL back_to_back[%0d] flush got %0d want %0d", i, flush_b, e.flush);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t sq[$];
    exp_t  eq[$];
    do_reset();
    for (int k = 0; k < 20; k++) begin
      sq.push_back(haz_rs(5'd8));
      eq.push_back(ex(OStall, (k > 15) ? 15 : k, 0));
    end
    sq.push_back(idle());           eq.push_back(ex(ORun, 15, 0));
    for (int i = 0; i < sq.size(); i++) begin
      exp_t e;
      step(sq[i], eq[i]);
      e = sb_q.pop_front();
      checks += 2;
      if (out_c !== e.outs) begin
        errors++; $display("FAIL saturate[%0d] outs got %b want %b", i, out_c, e.outs);
      end
      if (stall_c !== 4'(e.stall)) begin
        errors++; $display("FAIL saturate[%0d] stall got %0d want %0d", i, stall_c, e.stall);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    stim_t sq[$];
    exp_t  eq[$];
    stim_t s;
    do_reset();
    s = idle(); s.br = 1'b1;
    sq.push_back(s);                eq.push_back(ex(OBr, 0, 0));
    sq.push_back(idle());           eq.push_back(ex(OFl, 0, 1));
    s = idle(); s.rst = 1'b0;
    sq.push_back(s);                eq.push_back(ex(ORst, 0, 1));
    sq.push_back(idle());           eq.push_back(ex(ORun, 0, 0));
    sq.push_back(haz_rs(5'd3));     eq.push_back(ex(OStall, 0, 0));
    sq.push_back(idle());           eq.push_back(ex(ORun, 1, 0));
    for (int i = 0; i < sq.size(); i++) begin
      exp_t e;
      step(sq[i], eq[i]);
      e = sb_q.pop_front();
      checks += 3;
      if (out_d !== e.outs) begin
        errors++; $display("FAIL rst_flush[%0d] outs got %b want %b", i, out_d, e.outs);
      end
      if (stall_d !== 16'(e.stall)) begin
        errors++; $display("FAIL rst_flush[%0d] stall got %0d want %0d", i, stall_d, e.stall);
      end
      if (flush_d !== 16'(e.flush)) begin
        errors++; $display("FAIL rst_flush[%0d] flush got %0d want %0d", i, flush_d, e.flush);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multi_stall();
    test_branch_vs_hazard();
    test_back_to_back();
    test_saturation();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached got running want finished");
    $fatal(1);
  end

endmodule
